// File: rtl/dot_pkg.sv
// Shared types and sizing helpers for the dot-product accumulator.
package dot_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned PROD_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Sum of len full-scale products fits without overflow.
    function automatic int unsigned acc_width(input int unsigned len);
        return PROD_W + int'($clog2(len));
    endfunction

    function automatic int unsigned cnt_width(input int unsigned len);
        return (len > 1) ? int'($clog2(len)) : 1;
    endfunction

endpackage

// File: rtl/dot_accumulator_mul.sv
// Combinational 4x4 unsigned array multiplier with scalar bit ports.
module dot_mul4x4
    import dot_pkg::*;
(
    input  logic a0_i,
    input  logic a1_i,
    input  logic a2_i,
    input  logic a3_i,
    input  logic b0_i,
    input  logic b1_i,
    input  logic b2_i,
    input  logic b3_i,
    output logic p0_o,
    output logic p1_o,
    output logic p2_o,
    output logic p3_o,
    output logic p4_o,
    output logic p5_o,
    output logic p6_o,
    output logic p7_o
);

    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [PROD_W-1:0] p;

    assign a = {a3_i, a2_i, a1_i, a0_i};
    assign b = {b3_i, b2_i, b1_i, b0_i};

    // Sum of shifted AND-gated partial-product rows.
    always_comb begin
        p = '0;
        for (int i = 0; i < int'(OPND_W); i++) begin
            p = p + (PROD_W'({OPND_W{b[i]}} & a) << i);
        end
    end

    assign {p7_o, p6_o, p5_o, p4_o, p3_o, p2_o, p1_o, p0_o} = p;

endmodule

// File: rtl/dot_accumulator.sv
// Pipelined MAC: accumulates LEN products of 4-bit operand pairs into one sum.
// Optional DOT_PERF_CNT_EN adds a 16-bit count of completed output handshakes.
module dot_accumulator
    import dot_pkg::*;
#(
    parameter  int unsigned LEN   = 4,
    localparam int unsigned ACC_W = acc_width(LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              busy
`ifdef DOT_PERF_CNT_EN
    ,
    output logic [15:0]       perf_cnt
`endif
);

    localparam int unsigned     CNT_W     = cnt_width(LEN);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(LEN - 1);

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  term_cnt_q,  term_cnt_d;
    logic [PROD_W-1:0] prod_q,      prod_d;
    logic              prod_v_q,    prod_v_d;
    logic              prod_last_q, prod_last_d;
    logic              prod_first_q, prod_first_d;
    logic [ACC_W-1:0]  acc_q,       acc_d;
    logic [ACC_W-1:0]  out_sum_q,   out_sum_d;
    logic              out_valid_q, out_valid_d;

    logic [PROD_W-1:0] mul_p;
    logic              accept_c;
    logic              out_hs_c;
    logic [ACC_W-1:0]  acc_sum_c;

    dot_mul4x4 u_mul (
        .a0_i (in_a[0]),
        .a1_i (in_a[1]),
        .a2_i (in_a[2]),
        .a3_i (in_a[3]),
        .b0_i (in_b[0]),
        .b1_i (in_b[1]),
        .b2_i (in_b[2]),
        .b3_i (in_b[3]),
        .p0_o (mul_p[0]),
        .p1_o (mul_p[1]),
        .p2_o (mul_p[2]),
        .p3_o (mul_p[3]),
        .p4_o (mul_p[4]),
        .p5_o (mul_p[5]),
        .p6_o (mul_p[6]),
        .p7_o (mul_p[7])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            term_cnt_q   <= '0;
            prod_q       <= '0;
            prod_v_q     <= 1'b0;
            prod_last_q  <= 1'b0;
            prod_first_q <= 1'b0;
            acc_q        <= '0;
            out_sum_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            term_cnt_q   <= term_cnt_d;
            prod_q       <= prod_d;
            prod_v_q     <= prod_v_d;
            prod_last_q  <= prod_last_d;
            prod_first_q <= prod_first_d;
            acc_q        <= acc_d;
            out_sum_q    <= out_sum_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        term_cnt_d   = term_cnt_q;
        prod_d       = prod_q;
        prod_v_d     = 1'b0;
        prod_last_d  = prod_last_q;
        prod_first_d = prod_first_q;
        acc_d        = acc_q;
        out_sum_d    = out_sum_q;
        out_valid_d  = out_valid_q;
        in_ready     = 1'b0;
        accept_c     = 1'b0;
        out_hs_c     = 1'b0;
        acc_sum_c    = '0;

        // Stall intake while the closing product drains into the result.
        if (state_q == ACCUM) begin
            in_ready = !(prod_v_q && prod_last_q);
        end
        accept_c = in_valid && in_ready;

        if (accept_c) begin
            prod_d       = mul_p;
            prod_v_d     = 1'b1;
            prod_last_d  = (term_cnt_q == LAST_TERM);
            prod_first_d = (term_cnt_q == '0);
            term_cnt_d   = (term_cnt_q == LAST_TERM) ? '0 : term_cnt_q + CNT_W'(1);
        end

        acc_sum_c = prod_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
        if (prod_v_q) begin
            if (prod_last_q) begin
                out_sum_d   = acc_sum_c;
                out_valid_d = 1'b1;
                acc_d       = '0;
                state_d     = HOLD;
            end else begin
                acc_d = acc_sum_c;
            end
        end

        case (state_q)
            HOLD: begin
                out_hs_c = out_valid_q && out_ready;
                if (out_hs_c) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = (term_cnt_q != '0) || prod_v_q || (state_q == HOLD);

`ifdef DOT_PERF_CNT_EN
    logic [15:0] perf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= '0;
        end else if (out_hs_c) begin
            perf_cnt_q <= perf_cnt_q + 16'd1;
        end
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed scoreboard bench for dot_accumulator at LEN=4.
module tb_dot_accumulator;

    localparam int unsigned LEN   = 4;
    localparam int unsigned ACC_W = 8 + $clog2(LEN);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             busy;
`ifdef DOT_PERF_CNT_EN
    logic [15:0]      perf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_hs  = 0;
    int unsigned sb_q[$];
    int unsigned model_acc = 0;
    int unsigned model_cnt = 0;

    dot_accumulator #(.LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
`ifdef DOT_PERF_CNT_EN
        ,
        .perf_cnt  (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: count accepts and compare results on each output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) begin
                n_hs++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_out: observed %0d expected none", out_sum);
                end else begin
                    check("out_sum", 32'(out_sum), sb_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout: observed in_ready=0 expected in_ready=1 within 50 cycles");
        end
        step();
        model_acc += 32'(a) * 32'(b);
        model_cnt++;
        if (model_cnt == LEN) begin
            sb_q.push_back(model_acc);
            model_acc = 0;
            model_cnt = 0;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((sb_q.size() != 0 || out_valid) && n < 30) begin
            step();
            n++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int acc_before;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        step();
        step();
        #2 rst = 1'b0;
        step();

        // Full-scale back-to-back terms: 4 * 225.
        for (int i = 0; i < 4; i++) send(4'd15, 4'd15);
        in_valid = 1'b0;
        check("t1_no_early_valid", 32'(out_valid), 32'd0);
        check("t1_ready_low_last", 32'(in_ready),  32'd0);
        step();
        check("t1_latency_valid",  32'(out_valid), 32'd1);
        check("t1_busy_hold",      32'(busy),      32'd1);
        step();
        check("t1_single_pulse",   32'(out_valid), 32'd0);
        check("t1_ready_back",     32'(in_ready),  32'd1);
        check("t1_idle_busy",      32'(busy),      32'd0);

        // Gapped terms, then back-pressure with in_valid held high.
        out_ready = 1'b0;
        send(4'd1, 4'd1); in_valid = 1'b0; step();
        send(4'd2, 4'd1); in_valid = 1'b0; step();
        send(4'd3, 4'd1); in_valid = 1'b0; step();
        send(4'd4, 4'd1);
        in_a = 4'd1;
        in_b = 4'd1;
        step();
        acc_before = n_acc;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(out_valid), 32'd1);
            check("t2_hold_sum",   32'(out_sum),   32'd10);
            check("t2_hold_ready", 32'(in_ready),  32'd0);
            step();
        end
        check("t2_no_accepts", 32'(n_acc), 32'(acc_before));
        out_ready = 1'b1;
        step();
        check("t2_hs_valid_low", 32'(out_valid), 32'd0);
        check("t2_hs_ready",     32'(in_ready),  32'd1);
        check("t2_hs_no_accept", 32'(n_acc),     32'(acc_before));
        send(4'd1, 4'd1);
        check("t2_next_accept",  32'(n_acc),     32'(acc_before + 1));
        check("t2_next_busy",    32'(busy),      32'd1);
        for (int i = 0; i < 3; i++) send(4'd2, 4'd2);
        drain("t2_drain");

        // Two products back to back; the second must not inherit the first.
        for (int i = 0; i < 4; i++) send(4'd2, 4'd3);
        for (int i = 0; i < 4; i++) send(4'd0, 4'd7);
        drain("t3_drain");
`ifdef DOT_PERF_CNT_EN
        check("perf_cnt_5", 32'(perf_cnt), 32'd5);
`endif

        // Asynchronous reset in the middle of a product.
        send(4'd5, 4'd5);
        send(4'd5, 4'd5);
        in_valid = 1'b0;
        check("t4_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_valid",    32'(out_valid), 32'd0);
        check("t4_rst_busy",     32'(busy),      32'd0);
        check("t4_rst_in_ready", 32'(in_ready),  32'd1);
`ifdef DOT_PERF_CNT_EN
        check("perf_cnt_rst", 32'(perf_cnt), 32'd0);
`endif
        model_acc = 0;
        model_cnt = 0;
        #1 rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) send(4'd1, 4'd2);
        drain("t4_drain");

        check("total_handshakes", 32'(n_hs), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
